// File: rtl/im_loader_if.sv
// im_loader_if -- byte-stream handshake between an image producer and im_loader.
//
// Signals:
//   byte_valid  producer presents a byte
//   byte_data   instruction byte, big-endian order within each 32-bit word
//   byte_last   marks the final byte of the image (meaningful only on acceptance)
//   byte_ready  loader can accept a byte this cycle
//
// Modports: master = producer side, slave = loader side.
interface im_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    output byte_last,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    input  byte_last,
    output byte_ready
  );
endinterface

// File: rtl/im_loader.sv
// im_loader -- loads a byte-serial instruction image into a 2^ADDR_W x 32-bit
// instruction memory and serves combinational instruction fetches from it.
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset (memory contents survive it)
//   start       single-cycle request to begin/restart a load at word 0
//   bif         byte-stream handshake (slave modport of im_loader_if)
//   busy        high while loading
//   done        high once a load has finished (last byte or memory full)
//   full        the final memory word was written by the load
//   word_count  words written by the current/last load
//   fetch_addr  CPU word address for instruction fetch
//   instr       memory word at fetch_addr (combinational read)
//   checksum    running modulo-2^32 sum of written words
//
// Optional feature: define IM_LOADER_CHECKSUM_EN to build the checksum adder;
// without it checksum is tied to zero.
module im_loader #(
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  im_loader_if.slave          bif,
  output logic                busy,
  output logic                done,
  output logic                full,
  output logic [ADDR_W:0]     word_count,
  input  logic [ADDR_W+1:2]   fetch_addr,
  output logic [31:0]         instr,
  output logic [31:0]         checksum
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   WCNT_ONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   waddr_q;
  logic [1:0]          bidx_q;
  logic [ADDR_W:0]     wcnt_q;
  logic                full_q;
  logic [31:0]         word_q;

  logic [31:0]         mem [DEPTH];

  logic                accept;
  logic                wr_en;
  logic                wr_final;
  logic [31:0]         wdata;

  // start takes priority over a concurrent byte, which is dropped.
  assign accept   = bif.byte_valid && (state_q == LOAD) && !start;
  assign wr_en    = accept && (bif.byte_last || (bidx_q == 2'd3));
  assign wr_final = wr_en && (bif.byte_last || (waddr_q == ADDR_MAX));

  // Merge the incoming byte into its big-endian lane. Lanes below the current
  // byte are always zero here, so a last byte at index 0..2 yields a padded word.
  always_comb begin
    wdata = 32'h0;
    unique case (bidx_q)
      2'd0: wdata = {bif.byte_data, 24'h0};
      2'd1: wdata = {word_q[31:24], bif.byte_data, 16'h0};
      2'd2: wdata = {word_q[31:16], bif.byte_data, 8'h0};
      2'd3: wdata = {word_q[31:8], bif.byte_data};
      default: wdata = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        if (start)         state_d = LOAD;
        else if (wr_final) state_d = DONE;
      end
      DONE: if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      waddr_q <= '0;
      bidx_q  <= 2'd0;
      wcnt_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        waddr_q <= '0;
        bidx_q  <= 2'd0;
        wcnt_q  <= '0;
        full_q  <= 1'b0;
      end else if (accept) begin
        if (wr_en) begin
          bidx_q <= 2'd0;
          wcnt_q <= wcnt_q + WCNT_ONE;
          // The write address saturates at the top word instead of wrapping.
          if (waddr_q == ADDR_MAX) full_q  <= 1'b1;
          else                     waddr_q <= waddr_q + ADDR_ONE;
        end else begin
          bidx_q <= bidx_q + 2'd1;
        end
      end
    end
  end

  // Partial-word holding register needs no reset: byte index 0 overwrites it.
  always_ff @(posedge clk) begin
    if (accept) word_q <= wdata;
  end

  // Memory has no reset so contents persist across reset and restarts.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr_q] <= wdata;
  end

  assign instr = mem[fetch_addr];

`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0] cksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cksum_q <= 32'h0;
    else if (start)  cksum_q <= 32'h0;
    else if (wr_en)  cksum_q <= cksum_q + wdata;
  end

  assign checksum = cksum_q;
`else
  assign checksum = 32'h0;
`endif

  assign bif.byte_ready = (state_q == LOAD);
  assign busy           = (state_q == LOAD);
  assign done           = (state_q == DONE);
  assign full           = full_q;
  assign word_count     = wcnt_q;

endmodule

// File: tb/tb_im_loader.sv
module tb_im_loader;
  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              done;
  logic              full;
  logic [ADDR_W:0]   word_count;
  logic [ADDR_W+1:2] fetch_addr;
  logic [31:0]       instr;
  logic [31:0]       checksum;

  int n_cmp;
  int n_bad;

  im_loader_if bif ();

  im_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bif        (bif),
    .busy       (busy),
    .done       (done),
    .full       (full),
    .word_count (word_count),
    .fetch_addr (fetch_addr),
    .instr      (instr),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one byte for exactly one rising edge.
  task automatic send_byte(input logic [7:0] d, input logic last);
    @(negedge clk);
    bif.byte_valid = 1'b1;
    bif.byte_data  = d;
    bif.byte_last  = last;
    @(posedge clk);
    #1;
    bif.byte_valid = 1'b0;
    bif.byte_last  = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    send_byte(w[31:24], 1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[15:8],  1'b0);
    send_byte(w[7:0],   last);
  endtask

  task automatic fetch(input int a, output logic [31:0] v);
    fetch_addr = a[ADDR_W-1:0];
    #1;
    v = instr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bif.byte_ready, busy, done, full} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags got %b want 0000", {bif.byte_ready, busy, done, full});
    end
    n_cmp++;
    if (word_count !== 11'd0 || checksum !== 32'h0) begin
      n_bad++; $display("FAIL reset_counts got wc=%0d ck=%h want 0/0", word_count, checksum);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    logic [31:0] v;
    pulse_start();
    n_cmp++;
    if ({busy, bif.byte_ready, done} !== 3'b110) begin
      n_bad++; $display("FAIL start_flags got %b want 110", {busy, bif.byte_ready, done});
    end
    send_byte(8'h8C, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    n_cmp++;
    if (word_count !== 11'd0) begin
      n_bad++; $display("FAIL partial_wc got %0d want 0", word_count);
    end
    send_byte(8'h04, 1'b1);
    n_cmp++;
    if ({done, busy, bif.byte_ready} !== 3'b100 || word_count !== 11'd1) begin
      n_bad++; $display("FAIL single_done got flags=%b wc=%0d want 100/1", {done, busy, bif.byte_ready}, word_count);
    end
    fetch(0, v);
    n_cmp++;
    if (v !== 32'h8C010004) begin
      n_bad++; $display("FAIL single_mem0 got %h want 8C010004", v);
    end
    // A byte offered in DONE must be ignored.
    send_byte(8'hEE, 1'b1);
    n_cmp++;
    if (word_count !== 11'd1 || done !== 1'b1) begin
      n_bad++; $display("FAIL ignore_in_done got wc=%0d done=%b want 1/1", word_count, done);
    end
  endtask

  task automatic test_padded_last();
    logic [31:0] v;
    logic [31:0] exp_ck;
`ifdef IM_LOADER_CHECKSUM_EN
    exp_ck = 32'h26283314;
`else
    exp_ck = 32'h0;
`endif
    pulse_start();
    n_cmp++;
    if (word_count !== 11'd0 || checksum !== 32'h0) begin
      n_bad++; $display("FAIL start_clear got wc=%0d ck=%h want 0/0", word_count, checksum);
    end
    for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i), (i == 5));
    n_cmp++;
    if (word_count !== 11'd2 || done !== 1'b1) begin
      n_bad++; $display("FAIL pad_wc got wc=%0d done=%b want 2/1", word_count, done);
    end
    fetch(0, v);
    n_cmp++;
    if (v !== 32'h11121314) begin
      n_bad++; $display("FAIL pad_mem0 got %h want 11121314", v);
    end
    fetch(1, v);
    n_cmp++;
    if (v !== 32'h15160000) begin
      n_bad++; $display("FAIL pad_mem1 got %h want 15160000", v);
    end
    n_cmp++;
    if (checksum !== exp_ck) begin
      n_bad++; $display("FAIL pad_checksum got %h want %h", checksum, exp_ck);
    end
  endtask

  task automatic test_restart();
    logic [31:0] v;
    pulse_start();
    for (int w = 0; w < 5; w++) send_word(32'hA0A0_0000 + 32'(w), 1'b0);
    n_cmp++;
    if (word_count !== 11'd5) begin
      n_bad++; $display("FAIL restart_pre_wc got %0d want 5", word_count);
    end
    // start together with a valid byte: byte is dropped, load restarts.
    @(negedge clk);
    start = 1'b1;
    bif.byte_valid = 1'b1;
    bif.byte_data  = 8'h77;
    @(posedge clk);
    #1;
    start = 1'b0;
    bif.byte_valid = 1'b0;
    n_cmp++;
    if (word_count !== 11'd0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL restart_clear got wc=%0d busy=%b want 0/1", word_count, busy);
    end
    send_word(32'hCAFEF00D, 1'b0);
    n_cmp++;
    if (word_count !== 11'd1) begin
      n_bad++; $display("FAIL restart_wc1 got %0d want 1", word_count);
    end
    fetch(0, v);
    n_cmp++;
    if (v !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL restart_mem0 got %h want CAFEF00D", v);
    end
    fetch(4, v);
    n_cmp++;
    if (v !== 32'hA0A00004) begin
      n_bad++; $display("FAIL restart_mem4 got %h want A0A00004", v);
    end
  endtask

  task automatic test_reset_midword();
    logic [31:0] v;
    pulse_start();
    for (int w = 0; w < 3; w++) send_word(32'h5000_0000 + 32'(w), 1'b0);
    send_byte(8'h99, 1'b0);
    send_byte(8'h88, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, bif.byte_ready} !== 3'b000 || word_count !== 11'd0) begin
      n_bad++; $display("FAIL midreset got flags=%b wc=%0d want 000/0", {busy, done, bif.byte_ready}, word_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fetch(3, v);
    n_cmp++;
    if (v !== 32'hA0A00003) begin
      n_bad++; $display("FAIL midreset_mem3 got %h want A0A00003", v);
    end
    fetch(2, v);
    n_cmp++;
    if (v !== 32'h50000002) begin
      n_bad++; $display("FAIL midreset_mem2 got %h want 50000002", v);
    end
  endtask

  task automatic test_fill();
    logic [31:0] v;
    pulse_start();
    for (int i = 0; i < 4096; i++) begin
      if (i == 4095) begin
        n_cmp++;
        if (full !== 1'b0 || word_count !== 11'd1023) begin
          n_bad++; $display("FAIL fill_prelast got full=%b wc=%0d want 0/1023", full, word_count);
        end
      end
      send_byte(8'(i), 1'b0);
      if (i[0]) @(posedge clk);
    end
    #1;
    n_cmp++;
    if ({full, done, bif.byte_ready, busy} !== 4'b1100 || word_count !== 11'd1024) begin
      n_bad++; $display("FAIL fill_end got flags=%b wc=%0d want 1100/1024", {full, done, bif.byte_ready, busy}, word_count);
    end
    send_byte(8'h55, 1'b1);
    n_cmp++;
    if (word_count !== 11'd1024 || full !== 1'b1) begin
      n_bad++; $display("FAIL fill_extra got wc=%0d full=%b want 1024/1", word_count, full);
    end
    fetch(0, v);
    n_cmp++;
    if (v !== 32'h00010203) begin
      n_bad++; $display("FAIL fill_mem0 got %h want 00010203", v);
    end
    fetch(1023, v);
    n_cmp++;
    if (v !== 32'hFCFDFEFF) begin
      n_bad++; $display("FAIL fill_mem1023 got %h want FCFDFEFF", v);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b1;
    start = 1'b0;
    fetch_addr = '0;
    bif.byte_valid = 1'b0;
    bif.byte_data  = 8'h00;
    bif.byte_last  = 1'b0;
    #2;
    test_reset();
    test_single_word();
    test_padded_last();
    test_restart();
    test_reset_midword();
    test_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
